hdlc_deframer: RTL and testbench
================================

# hdlc_deframer

Receive-side HDLC deframer directly downstream of the flag/abort/stuff-bit detector FSM. It watches the same serial bit stream plus the detector's registered `disc`/`flag`/`err` strobes. It removes stuffed zeros and flag bits and assembles LSB-first bytes. At every closing flag it reports the frame result as good, bad or aborted.

## Interface
- `MIN_BYTES`, default 4: minimum committed byte count for a good frame.
- `clk` input 1: sole clock, rising edge.
- `areset_n` input 1: asynchronous, active-low reset.
- `in` input 1: serial line bit, same signal the detector samples.
- `disc` input 1: detector strobe; high in the cycle after a stuffed 0 was sampled.
- `flag` input 1: detector strobe; high in the cycle after the final 0 of 01111110 was sampled.
- `err` input 1: detector strobe; high in the cycle after a seventh consecutive 1 was sampled. May stay high.
- `out_byte` output 8: assembled data byte. First committed bit goes to bit 0.
- `out_valid` output 1: one-cycle pulse when `out_byte` is new.
- `out_sof` output 1: high with `out_valid` on the first byte of a frame.
- `frame_ok` output 1: one-cycle pulse; the closed frame is good.
- `frame_bad` output 1: one-cycle pulse; the closed frame is short, misaligned or has a CRC failure.
- `frame_abort` output 1: one-cycle pulse; the frame was killed by `err`.

## Operation
- States:
  - HUNT: reset state; ignore data until the first flag.
  - OPEN: flag seen, no data committed yet.
  - DATA: receiving frame data.
- Delay line D[1..8] holds {bit, valid}; D[1] is newest. Every edge does the following in order:
  - Consider the exiting entry D[8].
  - Shift.
  - Load D[1] <= {in, 1}.
- Commit rule: D[8] bit is committed when D[8].valid=1, state is OPEN or DATA, and `flag`=0 and `err`=0 at that edge.
- `disc`=1: clear valid of D[2] after the shift. That entry is the stuffed 0.
- `flag`=1: clear valid of D[2..8] after the shift and suppress the exiting D[8]. This drops all 8 flag bits. D[1] is kept as the first bit of the next frame.
- `err`=1: clear valid of D[1..8] and go to HUNT. If the state was DATA, pulse `frame_abort`. Otherwise no pulse.
- `flag` transitions:
  - HUNT → OPEN, no pulse.
  - OPEN → OPEN, no pulse; back-to-back flags are idle.
  - DATA → OPEN with exactly one result pulse: `frame_ok` if bit count mod 8 = 0, byte count ≥ MIN_BYTES and the CRC passes. Otherwise `frame_bad`.
- A commit in OPEN goes to DATA. Clear the bit/byte counters and the shift byte, and mark the next emitted byte `out_sof`.
- Byte assembly: committed bits shift in LSB-first. The 8th bit produces `out_valid`.
- Byte count is 16 bits and saturates at 0xFFFF.
- No backpressure. The consumer must accept every `out_valid`.
- If `err` and `flag` are both high (not legal from the detector), `err` wins.

## Timing
- Every output is a register.
- Reset value of every output is 0. Reset also puts the block in HUNT and clears D valid bits, counters and CRC.
- Reset asserted mid-frame: outputs clear immediately. No result pulse is ever issued for that frame.
- Bit latency: a bit sampled at edge t is committed at edge t+8.
- `out_valid` is high in the cycle after the committing edge.
- Closing flag whose final 0 is sampled at edge t:
  - The last data bit commits at edge t at the latest.
  - The result pulse is high in the cycle after edge t+1.
  - The last byte's `out_valid` is therefore always ≥1 cycle before the result pulse.
- `frame_abort` is high in the cycle after the first edge seeing `err`=1. Repeated `err` cycles do not re-pulse.
- Minimum flag-to-flag spacing is 8 cycles. Shared-zero flags (011111101111110) each close or open correctly.

## Configuration
- `HDLC_DEFRAMER_FCS_EN` defined: a bit-serial CRC-16/X.25 runs over every committed bit.
  - Update per bit: fb = crc[0]^bit; crc = (crc>>1) ^ (fb ? 0x8408 : 0).
  - CRC is preset to 0xFFFF on every flag.
  - The CRC passes only if crc == 0xF0B8 at the closing flag.
- Macro undefined: no CRC logic; the CRC condition is treated as always true.

## Test plan
- Reset, then line 0x7E, 0xA5×4, 0x7E, all LSB-first: 4 `out_valid` with 0xA5, `out_sof` on the first, then one `frame_ok` pulse.
- Flag, 0xFF, 0x7C, 0x01, 0x3E with the bench stuffing after five 1s, then flag: bytes 0xFF, 0x7C, 0x01, 0x3E are emitted with stuffed zeros removed, then `frame_ok`.
- Flag, 0x12, 0x34, flag with MIN_BYTES=4: 2 bytes emitted, then `frame_bad`.
- Flag, 0xA5×4 + 3 extra bits, flag: 4 bytes emitted, then `frame_bad`.
- Flag, 0xA5×2, seven 1s, 0xA5×4, flag, 0x55×4, flag:
  - 2 bytes, then `frame_abort`.
  - Nothing while hunting.
  - The 0x55 frame then gives `frame_ok`.
- FCS_EN build: flag, 0x31..0x39, 0x6E, 0x90, flag gives `frame_ok`. The same frame with 0x35 flipped to 0x34 gives `frame_bad`.

Source files
------------

// File: rtl/hdlc_deframer.sv
// hdlc_deframer: HDLC receive deframer - drops stuffed zeros and flag bits, assembles LSB-first bytes, reports good/bad/aborted frames.
// Optional CRC-16/X.25 frame check sequence validation is enabled by defining HDLC_DEFRAMER_FCS_EN.
module hdlc_deframer #(
  parameter int MIN_BYTES = 4
) (
  input  logic       clk,
  input  logic       areset_n,
  input  logic       in,
  input  logic       disc,
  input  logic       flag,
  input  logic       err,
  output logic [7:0] out_byte,
  output logic       out_valid,
  output logic       out_sof,
  output logic       frame_ok,
  output logic       frame_bad,
  output logic       frame_abort
);
  localparam logic [1:0] HUNT = 2'd0;
  localparam logic [1:0] OPEN = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [7:0]  dbit_q, dbit_d, dval_q, dval_d;
  logic [7:0]  sh_q, sh_d, sh_base;
  logic [2:0]  bcnt_q, bcnt_d, bcnt_base;
  logic [15:0] bytes_q, bytes_d, bytes_base;
  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d, sof_q, sof_d;
  logic        ok_q, ok_d, bad_q, bad_d, abort_q, abort_d;
  logic        commit, crc_ok, good;

  // the bit leaving the 8-deep delay line is data only inside a frame and never on a flag/err edge
  assign commit = dval_q[7] && (state_q != HUNT) && !flag && !err;

`ifdef HDLC_DEFRAMER_FCS_EN
  logic [15:0] crc_q, crc_d;
  logic        fb;
  assign fb     = crc_q[0] ^ dbit_q[7];
  assign crc_ok = crc_q == 16'hF0B8;
  // CRC preset on every flag, one reflected update per committed bit
  always_comb begin
    crc_d = flag ? 16'hFFFF : commit ? (crc_q >> 1) ^ (fb ? 16'h8408 : 16'h0000) : crc_q;
  end
  // CRC register
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) crc_q <= 16'h0000;
    else           crc_q <= crc_d;
  end
`else
  assign crc_ok = 1'b1;
`endif

  assign good = (bcnt_q == 3'd0) && (bytes_q >= 16'(MIN_BYTES)) && crc_ok;

  // delay line, byte assembly, frame state and result pulses
  always_comb begin
    dbit_d     = {dbit_q[6:0], in};
    dval_d     = err ? 8'h00 : flag ? 8'h01 : {dval_q[6:0], 1'b1} & ~{6'b0, disc, 1'b0};
    sh_base    = (state_q == OPEN) ? 8'h00 : sh_q;
    bcnt_base  = (state_q == OPEN) ? 3'd0 : bcnt_q;
    bytes_base = (state_q == OPEN) ? 16'd0 : bytes_q;
    sh_d       = commit ? {dbit_q[7], sh_base[7:1]} : sh_q;
    bcnt_d     = commit ? bcnt_base + 3'd1 : bcnt_q;
    valid_d    = commit && (bcnt_base == 3'd7);
    byte_d     = valid_d ? sh_d : byte_q;
    sof_d      = valid_d && (bytes_base == 16'd0);
    bytes_d    = commit ? bytes_base + {15'd0, valid_d && (bytes_base != 16'hFFFF)} : bytes_q;
    state_d    = err ? HUNT : flag ? OPEN : commit ? DATA : state_q;
    ok_d       = !err && flag && (state_q == DATA) && good;
    bad_d      = !err && flag && (state_q == DATA) && !good;
    abort_d    = err && (state_q == DATA);
  end

  // state registers; outputs are registered and clear asynchronously
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= HUNT;
      dbit_q  <= 8'h00;
      dval_q  <= 8'h00;
      sh_q    <= 8'h00;
      bcnt_q  <= 3'd0;
      bytes_q <= 16'd0;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      ok_q    <= 1'b0;
      bad_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dbit_q  <= dbit_d;
      dval_q  <= dval_d;
      sh_q    <= sh_d;
      bcnt_q  <= bcnt_d;
      bytes_q <= bytes_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      ok_q    <= ok_d;
      bad_q   <= bad_d;
      abort_q <= abort_d;
    end
  end

  assign out_byte    = byte_q;
  assign out_valid   = valid_q;
  assign out_sof     = sof_q;
  assign frame_ok    = ok_q;
  assign frame_bad   = bad_q;
  assign frame_abort = abort_q;
endmodule

// File: tb/tb_hdlc_deframer.sv
// tb_hdlc_deframer: scoreboard bench for hdlc_deframer with a behavioural flag/abort/stuff detector driving the strobes.
module tb_hdlc_deframer;
  localparam logic [1:0] K_BYTE = 2'd0, K_OK = 2'd1, K_BAD = 2'd2, K_ABORT = 2'd3;
`ifdef HDLC_DEFRAMER_FCS_EN
  localparam bit FCS = 1'b1;
`else
  localparam bit FCS = 1'b0;
`endif
  localparam logic [1:0] K_NOFCS = FCS ? K_BAD : K_OK;

  typedef struct packed {logic [1:0] k; logic [7:0] d; logic s;} ev_t;

  logic clk = 1'b0, areset_n = 1'b0, line = 1'b1, disc = 1'b0, flag = 1'b0, err = 1'b0;
  logic [7:0] out_byte;
  logic out_valid, out_sof, frame_ok, frame_bad, frame_abort;
  ev_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  int ones = 0, sones = 0;
  logic p_disc = 1'b0, p_flag = 1'b0, p_err = 1'b0;
  logic [7:0] fcs_frame [0:10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};

  hdlc_deframer #(.MIN_BYTES(4)) dut (
    .clk(clk), .areset_n(areset_n), .in(line), .disc(disc), .flag(flag), .err(err),
    .out_byte(out_byte), .out_valid(out_valid), .out_sof(out_sof),
    .frame_ok(frame_ok), .frame_bad(frame_bad), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  // one line bit per cycle; detector strobes for a bit appear with the following bit
  task automatic send_bit(input logic b);
    @(negedge clk);
    line = b; disc = p_disc; flag = p_flag; err = p_err;
    if (b) begin
      ones++;
      p_err = ones >= 7; p_disc = 1'b0; p_flag = 1'b0;
    end else begin
      p_disc = ones == 5; p_flag = ones == 6; p_err = 1'b0;
      ones = 0;
    end
  endtask

  task automatic send_data_bit(input logic b);
    send_bit(b);
    if (b) begin
      sones++;
      if (sones == 5) begin send_bit(1'b0); sones = 0; end
    end else sones = 0;
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [7:0] d, input logic s);
    exp_q.push_back(ev_t'{k, d, s});
  endtask

  task automatic send_byte(input logic [7:0] v, input bit push, input bit sof);
    for (int i = 0; i < 8; i++) send_data_bit(v[i]);
    if (push) expect_ev(K_BYTE, v, sof);
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) send_bit(f[i]);
    sones = 0;
  endtask

  task automatic close_frame(input logic [1:0] k);
    send_flag();
    expect_ev(k, 8'h00, 1'b0);
  endtask

  task automatic check_ev(input logic [1:0] k, input logic [7:0] d, input logic s);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event: got kind=%0d byte=%02h sof=%0b, required no event", k, d, s);
    end else begin
      e = exp_q.pop_front();
      if (e != ev_t'{k, d, s}) begin
        n_fail++;
        $display("FAIL event: got kind=%0d byte=%02h sof=%0b, required kind=%0d byte=%02h sof=%0b", k, d, s, e.k, e.d, e.s);
      end
    end
  endtask

  task automatic check_idle(input string nm);
    n_chk++;
    if ({out_byte, out_valid, out_sof, frame_ok, frame_bad, frame_abort} != 13'd0) begin
      n_fail++;
      $display("FAIL %s: outputs=%04h, required 0000", nm, {out_byte, out_valid, out_sof, frame_ok, frame_bad, frame_abort});
    end
  endtask

  // monitor: every presented output event is compared against the scoreboard
  always @(negedge clk) begin
    if (areset_n) begin
      if (out_valid)   check_ev(K_BYTE, out_byte, out_sof);
      if (frame_ok)    check_ev(K_OK, 8'h00, 1'b0);
      if (frame_bad)   check_ev(K_BAD, 8'h00, 1'b0);
      if (frame_abort) check_ev(K_ABORT, 8'h00, 1'b0);
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check_idle("reset");
    areset_n = 1'b1;
    send_flag();
    for (int i = 0; i < 4; i++) send_byte(8'hA5, 1'b1, i == 0);
    close_frame(K_NOFCS);
    send_flag();
    send_byte(8'hFF, 1'b1, 1'b1);
    send_byte(8'h7C, 1'b1, 1'b0);
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h3E, 1'b1, 1'b0);
    close_frame(K_NOFCS);
    send_flag();
    send_byte(8'h12, 1'b1, 1'b1);
    send_byte(8'h34, 1'b1, 1'b0);
    close_frame(K_BAD);
    send_flag();
    for (int i = 0; i < 4; i++) send_byte(8'hA5, 1'b1, i == 0);
    send_data_bit(1'b1);
    send_data_bit(1'b0);
    send_data_bit(1'b1);
    close_frame(K_BAD);
    send_flag();
    send_byte(8'hA5, 1'b1, 1'b1);
    send_byte(8'hA5, 1'b1, 1'b0);
    send_bit(1'b0);
    repeat (7) send_bit(1'b1);
    sones = 0;
    expect_ev(K_ABORT, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'hA5, 1'b0, 1'b0);
    send_flag();
    for (int i = 0; i < 4; i++) send_byte(8'h55, 1'b1, i == 0);
    close_frame(K_NOFCS);
    send_flag();
    for (int i = 0; i < 11; i++) send_byte(fcs_frame[i], 1'b1, i == 0);
    close_frame(K_OK);
    send_flag();
    for (int i = 0; i < 11; i++) send_byte(i == 4 ? 8'h34 : fcs_frame[i], 1'b1, i == 0);
    close_frame(FCS ? K_BAD : K_OK);
    send_flag();
    send_byte(8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_data_bit(i[0]);
    @(negedge clk);
    areset_n = 1'b0;
    #1;
    check_idle("midframe reset");
    ones = 0; sones = 0; p_disc = 1'b0; p_flag = 1'b0; p_err = 1'b0;
    disc = 1'b0; flag = 1'b0; err = 1'b0;
    @(negedge clk);
    areset_n = 1'b1;
    repeat (3) send_flag();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending: %0d expected events not seen, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
